// File: rtl/gate_bist_checker_if.sv
// rtl/gate_bist_checker_if.sv - start/response/result bundle between the gate BIST sequencer and its user
interface gate_bist_checker_if #(
  parameter int N_IN = 2
);
  logic                  in_start;
  logic                  in_resp;
  logic [N_IN-1:0]       out_vec;
  logic                  out_busy;
  logic                  out_done;
  logic                  out_pass;
  logic [(1<<N_IN)-1:0]  out_fail_mask;
  logic [N_IN:0]         out_fail_count;

  modport master (
    input  in_start,
    input  in_resp,
    output out_vec,
    output out_busy,
    output out_done,
    output out_pass,
    output out_fail_mask,
    output out_fail_count
  );

  modport slave (
    output in_start,
    output in_resp,
    input  out_vec,
    input  out_busy,
    input  out_done,
    input  out_pass,
    input  out_fail_mask,
    input  out_fail_count
  );
endinterface

// File: rtl/gate_bist_checker.sv
// rtl/gate_bist_checker.sv - exhaustive-vector BIST sequencer that sweeps a small gate and checks it against a truth table
module gate_bist_checker #(
  parameter int                   N_IN   = 2,
  parameter int                   SETTLE = 2,
  parameter logic [(1<<N_IN)-1:0] EXPECT = 4'b0111
) (
  input  logic                in_clk,
  input  logic                in_rst,
  gate_bist_checker_if.master bus
);
  localparam int              NV          = 1 << N_IN;
  localparam logic [N_IN-1:0] LAST_IDX    = {N_IN{1'b1}};
  localparam logic [3:0]      SETTLE_LOAD = 4'(SETTLE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_SETTLE,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t          r_state, w_state_next;
  logic [N_IN-1:0] r_idx, w_idx_next;
  logic [3:0]      r_cnt, w_cnt_next;
  logic [N_IN-1:0] r_vec, w_vec_next;
  logic [NV-1:0]   r_mask, w_mask_next;
  logic [N_IN:0]   r_count, w_count_next;
  logic            r_pass, w_pass_next;
  logic            w_mismatch;

  assign w_mismatch = (bus.in_resp != EXPECT[r_idx]);

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_vec   <= '0;
      r_mask  <= '0;
      r_count <= '0;
      r_pass  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
      r_cnt   <= w_cnt_next;
      r_vec   <= w_vec_next;
      r_mask  <= w_mask_next;
      r_count <= w_count_next;
      r_pass  <= w_pass_next;
    end
  end

  // The vector register loads as APPLY ends, so the sample in CAPTURE lands SETTLE+1 edges after it changes.
  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    w_cnt_next   = r_cnt;
    w_vec_next   = r_vec;
    w_mask_next  = r_mask;
    w_count_next = r_count;
    w_pass_next  = r_pass;
    unique case (r_state)
      S_IDLE, S_DONE: begin
        if (bus.in_start) begin
          w_state_next = S_APPLY;
          w_idx_next   = '0;
          w_vec_next   = '0;
          w_mask_next  = '0;
          w_count_next = '0;
          w_pass_next  = 1'b0;
        end
      end
      S_APPLY: begin
        w_vec_next   = r_idx;
        w_cnt_next   = SETTLE_LOAD;
        w_state_next = S_SETTLE;
      end
      S_SETTLE: begin
        if (r_cnt == 4'd0) begin
          w_state_next = S_CAPTURE;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end
      S_CAPTURE: begin
        if (w_mismatch) begin
          w_mask_next[r_idx] = 1'b1;
          w_count_next       = r_count + (N_IN+1)'(1);
        end
        if (r_idx == LAST_IDX) begin
          w_state_next = S_DONE;
          w_vec_next   = '0;
          w_pass_next  = (w_count_next == '0);
        end else begin
          w_idx_next   = r_idx + N_IN'(1);
          w_state_next = S_APPLY;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign bus.out_vec        = r_vec;
  assign bus.out_busy       = (r_state == S_APPLY) || (r_state == S_SETTLE) || (r_state == S_CAPTURE);
  assign bus.out_done       = (r_state == S_DONE);
  assign bus.out_pass       = r_pass;
  assign bus.out_fail_mask  = r_mask;
  assign bus.out_fail_count = r_count;
endmodule

// File: tb/tb_gate_bist_checker.sv
// tb/tb_gate_bist_checker.sv - directed-vector bench for gate_bist_checker
module tb_gate_bist_checker;
  logic in_clk;
  logic in_rst;
  logic tb_start;
  logic tb_sel;
  int   mode_a;
  int   n_checks;
  int   n_fail;

  gate_bist_checker_if #(.N_IN(2)) if_a ();
  gate_bist_checker_if #(.N_IN(2)) if_x ();

  gate_bist_checker u_nand (
    .in_clk (in_clk),
    .in_rst (in_rst),
    .bus    (if_a)
  );

  gate_bist_checker #(
    .N_IN   (2),
    .SETTLE (1),
    .EXPECT (4'b0110)
  ) u_xor (
    .in_clk (in_clk),
    .in_rst (in_rst),
    .bus    (if_x)
  );

  initial in_clk = 1'b0;
  always #5 in_clk = ~in_clk;

  // Gate models: 0 NAND, 1 AND, 2 stuck-at-1, 3 stuck-at-0; the second DUT always sees XOR.
  assign if_a.in_resp = (mode_a == 0) ? ~(if_a.out_vec[1] & if_a.out_vec[0]) :
                        (mode_a == 1) ?  (if_a.out_vec[1] & if_a.out_vec[0]) :
                        (mode_a == 2) ? 1'b1 : 1'b0;
  assign if_x.in_resp = if_x.out_vec[1] ^ if_x.out_vec[0];
  assign if_a.in_start = tb_start && !tb_sel;
  assign if_x.in_start = tb_start && tb_sel;

  wire [1:0] obs_vec  = tb_sel ? if_x.out_vec        : if_a.out_vec;
  wire       obs_busy = tb_sel ? if_x.out_busy       : if_a.out_busy;
  wire       obs_done = tb_sel ? if_x.out_done       : if_a.out_done;
  wire       obs_pass = tb_sel ? if_x.out_pass       : if_a.out_pass;
  wire [3:0] obs_mask = tb_sel ? if_x.out_fail_mask  : if_a.out_fail_mask;
  wire [2:0] obs_cnt  = tb_sel ? if_x.out_fail_count : if_a.out_fail_count;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_vec"},  {30'd0, if_a.out_vec}, 0);
    check({tag, "_busy"}, {31'd0, if_a.out_busy}, 0);
    check({tag, "_done"}, {31'd0, if_a.out_done}, 0);
    check({tag, "_pass"}, {31'd0, if_a.out_pass}, 0);
    check({tag, "_mask"}, {28'd0, if_a.out_fail_mask}, 0);
    check({tag, "_cnt"},  {29'd0, if_a.out_fail_count}, 0);
  endtask

  // Called #1 after an edge; issues the start pulse, then follows the sweep edge by edge.
  task automatic sweep(input bit sel, input int per, input int pulse_at,
                       input logic exp_pass, input logic [3:0] exp_mask, input logic [2:0] exp_cnt);
    int total;
    int c;
    bit seen;
    total = 4 * per;
    tb_sel = sel;
    tb_start = 1'b1;
    @(posedge in_clk);
    #1;
    tb_start = 1'b0;
    check("start_busy", {31'd0, obs_busy}, 1);
    check("start_done_low", {31'd0, obs_done}, 0);
    c = 0;
    seen = 1'b0;
    while (!seen && c < total + 8) begin
      @(posedge in_clk);
      #1;
      tb_start = 1'b0;
      c++;
      if (obs_done) begin
        seen = 1'b1;
      end else begin
        check("vec_step", {30'd0, obs_vec}, (c - 1) / per);
        if (c == pulse_at) tb_start = 1'b1;
      end
    end
    check("done_cycle", c, total);
    check("done_vec", {30'd0, obs_vec}, 0);
    check("done_busy", {31'd0, obs_busy}, 0);
    check("pass", {31'd0, obs_pass}, {31'd0, exp_pass});
    check("mask", {28'd0, obs_mask}, {28'd0, exp_mask});
    check("count", {29'd0, obs_cnt}, {29'd0, exp_cnt});
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    tb_start = 1'b0;
    tb_sel   = 1'b0;
    mode_a   = 0;
    in_rst   = 1'b0;
    #2;
    in_rst = 1'b1;
    #1;
    check_all_zero("reset");
    @(posedge in_clk);
    @(posedge in_clk);
    #1;
    in_rst = 1'b0;
    @(posedge in_clk);
    #1;
    check_all_zero("idle");

    sweep(1'b0, 4, 0, 1'b1, 4'b0000, 3'd0);
    mode_a = 1;
    sweep(1'b0, 4, 0, 1'b0, 4'b1111, 3'd4);
    mode_a = 2;
    sweep(1'b0, 4, 0, 1'b0, 4'b1000, 3'd1);

    // Reset during vector 1 settle: outputs must clear before any clock edge.
    mode_a = 0;
    tb_start = 1'b1;
    @(posedge in_clk);
    #1;
    tb_start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge in_clk);
    end
    #1;
    check("pre_rst_vec", {30'd0, if_a.out_vec}, 1);
    in_rst = 1'b1;
    #1;
    check_all_zero("mid_rst");
    @(posedge in_clk);
    #1;
    in_rst = 1'b0;
    @(posedge in_clk);
    @(posedge in_clk);
    #1;
    check_all_zero("post_rst_idle");
    sweep(1'b0, 4, 0, 1'b1, 4'b0000, 3'd0);

    sweep(1'b0, 4, 5, 1'b1, 4'b0000, 3'd0);
    mode_a = 3;
    sweep(1'b0, 4, 0, 1'b0, 4'b0111, 3'd3);

    sweep(1'b1, 3, 0, 1'b1, 4'b0000, 3'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/gate_bist_checker.md
Name: gate_bist_checker

Overview:
- Hardware built-in self-test sequencer for the small combinational gate blocks in the 32-bRISC-V gate library, such as NAND, NOR and XOR.
- Drives every input vector into the gate under test, waits a fixed settle time, and samples the gate output.
- Compares each sample against a truth table set by parameter, then reports pass/fail plus a per-vector failure mask.
- Completes the stimulus-driving loop with a response-checking end, so gate checks can run on silicon or FPGA without a simulator.

Parameters:
- N_IN, 2, number of gate inputs; vector width. Legal range 1..4.
- SETTLE, 2, clock cycles a vector is held before sampling. Legal range 1..15.
- EXPECT, 4'b0111, expected truth table, 2**N_IN bits wide. Bit i is the expected output for input vector i. The default is NAND.

Ports:
- in_clk  input  1  single clock; all state updates on its rising edge.
- in_rst  input  1  asynchronous, active-high reset.
- in_start  input  1  one-cycle start pulse; ignored unless the FSM is in IDLE or DONE.
- in_resp  input  1  output of the gate under test.
- out_vec  output  N_IN  input vector driven to the gate under test.
- out_busy  output  1  high while a sweep is in progress.
- out_done  output  1  high in the DONE state; results are valid.
- out_pass  output  1  high in DONE when every vector matched; low otherwise.
- out_fail_mask  output  2**N_IN  bit i set when vector i mismatched.
- out_fail_count  output  N_IN+1  number of mismatched vectors.

Behaviour:
- Reset (asynchronous, takes effect immediately when in_rst rises, held while in_rst is high):
  - FSM goes to IDLE.
  - out_vec, out_busy, out_done, out_pass, out_fail_mask and out_fail_count are all 0.
  - Internal settle counter and vector index are 0.
- FSM states are IDLE, APPLY, SETTLE, CAPTURE, DONE.
- IDLE:
  - out_vec = 0.
  - On in_start = 1, go to APPLY.
  - In the same edge, clear out_fail_mask, out_fail_count and out_pass, and set the vector index to 0.
- APPLY (one cycle):
  - out_vec is driven with the vector index; out_busy = 1.
  - Load the settle counter with SETTLE-1, then go to SETTLE.
- SETTLE:
  - Decrement the counter each cycle; go to CAPTURE when the counter is 0.
  - out_vec is held stable throughout SETTLE.
- CAPTURE (one cycle):
  - Sample in_resp and compare with EXPECT[index].
  - On mismatch, set out_fail_mask[index] and increment out_fail_count.
  - If index = 2**N_IN - 1, go to DONE. Otherwise increment the index and go to APPLY.
- Latency from vector applied to sample:
  - in_resp is sampled exactly SETTLE+1 rising edges after out_vec changes.
  - A full sweep takes 2**N_IN × (SETTLE+2) cycles, from the first APPLY to the entry into DONE.
  - The defaults give 16 cycles.
- DONE:
  - out_busy = 0, out_done = 1.
  - out_pass = (out_fail_count == 0), registered on entry.
  - out_vec returns to 0.
  - Results hold until the next in_start or reset.
- in_start in DONE:
  - Behaves like in_start in IDLE: results clear and the FSM goes straight to APPLY.
  - out_done drops on the cycle APPLY is entered.
- in_start while out_busy = 1 is ignored; it does not restart the sweep or change the index.
- Index wrap-around: the index never exceeds 2**N_IN - 1 and does not wrap within a sweep.
- Reset mid-sweep: all results are discarded and the FSM returns to IDLE. No partial results appear.
- in_resp is treated as synchronous to in_clk; it is not synchronised.

Test Plan:
- Correct NAND, defaults (model in_resp = ~(a&b) from out_vec), pulse in_start:
  - out_vec steps 0,1,2,3, each held 4 cycles.
  - out_done rises 16 cycles after start.
  - out_pass = 1, out_fail_mask = 4'b0000, out_fail_count = 0.
- Faulty gate, in_resp = AND (a&b):
  - All vectors mismatch.
  - out_fail_mask = 4'b1111, out_fail_count = 4, out_pass = 0.
- Stuck-at-1 gate, in_resp = 1:
  - Only vector 3 fails.
  - out_fail_mask = 4'b1000, out_fail_count = 1, out_pass = 0.
- Correct NAND, assert in_rst in the 7th cycle of the sweep (during vector 1 SETTLE):
  - All outputs are 0 immediately, without waiting for an edge.
  - After release, the FSM is in IDLE.
  - A new in_start runs a full 16-cycle sweep with pass = 1.
- Correct NAND, pulse in_start again during the sweep at cycle 5:
  - No effect; done still arrives at cycle 16.
  - Then a failing sweep (stuck-at-0) is started from DONE: out_done drops the next cycle, and the results show mask 4'b0111, count 3.
- Correct XOR gate, parameters SETTLE = 1 and EXPECT = 4'b0110:
  - Each vector is held 3 cycles; done at cycle 12.
  - out_pass = 1.
